// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel pushbutton debouncer.
//   hold_state_t : per-channel hold FSM states (IDLE, HELD, REPEAT)
//   clog2 / max2 : constant helpers for sizing counters
//   DEF_*        : default timing for the 100 MHz board, assuming the
//                  clock divider produces a 1 kHz sample strobe.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_SAMPLE_DIV     = 100_000; // 100 MHz / 1 kHz strobe
    localparam int DEF_STABLE_SAMPLES = 4;       // 4 ms of stable contact
    localparam int DEF_REPEAT_DELAY   = 250;     // 250 ms to long-press
    localparam int DEF_REPEAT_RATE    = 50;      // 20 repeats per second

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-FF synchroniser, debounce counter, hold FSM and
// registered press/release/long outputs.
// Ports:
//   clk         : system clock
//   clr         : asynchronous active-high reset, clears every flop
//   sample_en   : one-clk sampling strobe
//   btn_in      : raw asynchronous button input
//   btn_level   : debounced level
//   btn_press   : 1-clk pulse on debounced rise and on every auto-repeat
//   btn_release : 1-clk pulse on debounced fall
//   btn_long    : high while held for at least REPEAT_DELAY samples
module debounce_chan
    import btn_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic sample_en,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int CW = clog2(STABLE_SAMPLES + 1);
    localparam int HW = clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] DELAY_SAT  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;
    logic [HW-1:0] hcnt_reg;
    hold_state_t   state_reg;
    logic          press_reg;
    logic          release_reg;
    logic          long_reg;

    logic differ;
    logic settle;
    logic rise;
    logic fall;

    // The level flips on the strobe whose increment would reach
    // STABLE_SAMPLES, so the comparison is against STABLE_SAMPLES-1.
    assign differ = sync_reg[1] != level_reg;
    assign settle = sample_en && differ && (cnt_reg == CNT_LAST);
    assign rise   = settle && !level_reg;
    assign fall   = settle && level_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_reg    <= 2'b00;
            level_reg   <= 1'b0;
            cnt_reg     <= '0;
            hcnt_reg    <= '0;
            state_reg   <= IDLE;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn_in};
            press_reg   <= 1'b0;
            release_reg <= 1'b0;

            if (sample_en) begin
                if (!differ) begin
                    cnt_reg <= '0;
                end else if (settle) begin
                    level_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Pulses are set on the same edge that updates level_reg, so
            // they line up with the first cycle showing the new level.
            // A fall has priority over any repeat expiry.
            if (fall) begin
                state_reg   <= IDLE;
                hcnt_reg    <= '0;
                long_reg    <= 1'b0;
                release_reg <= 1'b1;
            end else if (rise) begin
                state_reg <= HELD;
                hcnt_reg  <= '0;
                press_reg <= 1'b1;
            end else if (sample_en) begin
                case (state_reg)
                    IDLE: begin
                    end
                    HELD: begin
                        // Once saturated at REPEAT_DELAY the count parks.
                        if (hcnt_reg != DELAY_SAT) begin
                            if (hcnt_reg == DELAY_LAST) begin
                                long_reg <= 1'b1;
                                if (REPEAT_EN) begin
                                    press_reg <= 1'b1;
                                    hcnt_reg  <= '0;
                                    state_reg <= REPEAT;
                                end else begin
                                    hcnt_reg <= DELAY_SAT;
                                end
                            end else begin
                                hcnt_reg <= hcnt_reg + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (hcnt_reg == RATE_LAST) begin
                            press_reg <= 1'b1;
                            hcnt_reg  <= '0;
                        end else begin
                            hcnt_reg <= hcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        hcnt_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_long    = long_reg;

endmodule

// File: rtl/debouncer_multi.sv
// N-channel pushbutton conditioner: debounced levels, press/release pulses,
// long-press flag and optional per-channel auto-repeat. All logic runs in
// the clk domain; state advances only on sample_en strobes.
// Ports:
//   clk         : system clock
//   clr         : asynchronous active-high reset
//   sample_en   : one-clk sampling strobe from the clock divider
//   btn_in      : raw button inputs, one bit per channel
//   btn_level   : debounced levels
//   btn_press   : press / auto-repeat pulses
//   btn_release : release pulses
//   btn_long    : long-press flags
module debouncer_multi
    import btn_pkg::*;
#(
    parameter int               N_BTN          = 3,
    parameter int               STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int               REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int               REPEAT_RATE    = DEF_REPEAT_RATE,
    parameter logic [N_BTN-1:0] REPEAT_MASK    = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    generate
        if (N_BTN < 1 || STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("debouncer_multi: N_BTN, STABLE_SAMPLES, REPEAT_DELAY and REPEAT_RATE must all be >= 1");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            debounce_chan #(
                .STABLE_SAMPLES (STABLE_SAMPLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE),
                .REPEAT_EN      (REPEAT_MASK[gi])
            ) u_chan (
                .clk         (clk),
                .clr         (clr),
                .sample_en   (sample_en),
                .btn_in      (btn_in[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi]),
                .btn_long    (btn_long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi. The stimulus process drives inputs
// on the falling edge and advances a behavioural model that works in terms
// of "consecutive disagreeing strobes" and "strobes held since the rise";
// predicted pulse events are queued and a monitor process pops them when
// the DUT pulses. Levels and long flags are compared every cycle.
module tb_debouncer_multi;

    localparam int         N    = 3;
    localparam int         SS   = 4;
    localparam int         RD   = 8;
    localparam int         RR   = 3;
    localparam logic [2:0] MASK = 3'b001;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       sample_en = 1'b0;
    logic [2:0] btn_in = 3'b000;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic [2:0] btn_long;

    always #5 clk = ~clk;

    debouncer_multi #(
        .N_BTN          (N),
        .STABLE_SAMPLES (SS),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .sample_en   (sample_en),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tied     = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
    } ev_t;
    ev_t q[$];

    // Reference model state.
    bit         h1[N];
    bit         h2[N];
    bit         lvl[N];
    bit         lng[N];
    int         run[N];
    int         held[N];
    logic [2:0] exp_level = 3'b000;
    logic [2:0] exp_long  = 3'b000;

    task automatic model_step(input logic [2:0] b, input bit se, input bit c, input int edge_idx);
        logic [2:0] p;
        logic [2:0] r;
        p = 3'b000;
        r = 3'b000;
        for (int ch = 0; ch < N; ch++) begin
            bit s;
            bit was_high;
            bit toggled;
            if (c) begin
                h1[ch] = 1'b0; h2[ch] = 1'b0; lvl[ch] = 1'b0; lng[ch] = 1'b0;
                run[ch] = 0; held[ch] = 0;
            end else begin
                // Value seen by the debouncer is the input from two edges ago.
                s = h2[ch];
                h2[ch] = h1[ch];
                h1[ch] = b[ch];
                if (se) begin
                    was_high = lvl[ch];
                    toggled  = 1'b0;
                    if (s != lvl[ch]) begin
                        run[ch]++;
                        if (run[ch] == SS) begin
                            run[ch] = 0;
                            lvl[ch] = ~lvl[ch];
                            toggled = 1'b1;
                        end
                    end else begin
                        run[ch] = 0;
                    end
                    if (toggled) begin
                        held[ch] = 0;
                        if (lvl[ch]) p[ch] = 1'b1;
                        else begin
                            r[ch]   = 1'b1;
                            lng[ch] = 1'b0;
                        end
                    end else if (was_high) begin
                        held[ch]++;
                        if (held[ch] >= RD) lng[ch] = 1'b1;
                        if (MASK[ch] && held[ch] >= RD && ((held[ch] - RD) % RR) == 0) p[ch] = 1'b1;
                    end
                end
            end
            exp_level[ch] = lvl[ch];
            exp_long[ch]  = lng[ch];
        end
        if ((p | r) != 3'b000) q.push_back('{edge_idx, p, r});
    endtask

    task automatic step(input logic [2:0] b, input bit c);
        @(negedge clk);
        btn_in    = b;
        clr       = c;
        sample_en = tied ? 1'b1 : (((cyc + 1) % 4) == 0);
        model_step(b, sample_en, c, cyc + 1);
    endtask

    task automatic hold(input logic [2:0] b, input int n, input bit c);
        repeat (n) step(b, c);
    endtask

    task automatic async_clr();
        @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_long} !== 12'h000) begin
            failures++;
            $display("FAIL async_clr got=%b want=0", {btn_level, btn_press, btn_release, btn_long});
        end
    endtask

    // Monitor: per-cycle level/long compare, plus scoreboard for pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            checks++;
            if (btn_level !== exp_level || btn_long !== exp_long) begin
                failures++;
                $display("FAIL level_long cyc=%0d got=%b/%b want=%b/%b", cyc, btn_level, btn_long, exp_level, exp_long);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_pulse cyc=%0d got=none want=p%b r%b", q[0].cyc, q[0].p, q[0].r);
                void'(q.pop_front());
            end
            if ((btn_press | btn_release) != 3'b000) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_pulse cyc=%0d got=p%b r%b want=none", cyc, btn_press, btn_release);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.p !== btn_press || e.r !== btn_release) begin
                        failures++;
                        $display("FAIL pulse cyc=%0d got=p%b r%b want=cyc%0d p%b r%b", cyc, btn_press, btn_release, e.cyc, e.p, e.r);
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] tgt;
        logic [2:0] b;
        logic [5:0] bounce;

        // Reset, then idle.
        hold(3'b000, 4, 1'b1);
        hold(3'b000, 8, 1'b0);

        // Clean press with auto-repeat on ch0 and plain long-press on ch2.
        hold(3'b101, 4 * 30, 1'b0);
        hold(3'b000, 40, 1'b0);

        // Bounce on ch1: per-strobe 1,0,1,1,1,1 then held, then a short pulse.
        bounce = 6'b111101;
        for (int i = 0; i < 6; i++) hold({1'b0, bounce[i], 1'b0}, 4, 1'b0);
        hold(3'b010, 32, 1'b0);
        hold(3'b000, 40, 1'b0);
        hold(3'b010, 12, 1'b0);
        hold(3'b000, 40, 1'b0);

        // Simultaneous presses, releases landing at each repeat phase.
        for (int k = 0; k < 5; k++) begin
            hold(3'b111, 4 * (13 + k), 1'b0);
            hold(3'b000, 40, 1'b0);
        end

        // Async reset while repeating, button kept held through it.
        hold(3'b111, 4 * 16, 1'b0);
        async_clr();
        hold(3'b111, 3, 1'b1);
        hold(3'b111, 4 * 20, 1'b0);
        hold(3'b000, 40, 1'b0);

        // Randomised bouncy operation, first strobed, then strobe tied high.
        tgt = 3'b000;
        for (int i = 0; i < 2100; i++) begin
            if (i == 1500) tied = 1'b1;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 99) == 0) tgt[ch] = ~tgt[ch];
            b = tgt;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 99) < 4) b[ch] = ~b[ch];
            step(b, 1'b0);
        end
        tied = 1'b0;
        hold(3'b000, 60, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- N-channel, parametrised successor to the board button debouncer. Conditions N raw pushbuttons into debounced levels, press/release pulses, a long-press flag and optional auto-repeat press pulses.
- Sits between the board pins and consumers such as image update, reset and display-mode logic.
- Samples on a strobe from clk_divider, so all control logic runs in the single clk domain.

Parameters:
N_BTN, 3, number of independent button channels
STABLE_SAMPLES, 4, consecutive differing samples required to change debounced level (>=1)
REPEAT_DELAY, 250, samples a level must stay high before btn_long asserts and the first repeat fires (>=1)
REPEAT_RATE, 50, samples between subsequent repeat pulses (>=1)
REPEAT_MASK, {N_BTN{1'b0}}, per-channel auto-repeat enable bit

Ports:
clk  in  1  system clock; only clock in the block
clr  in  1  asynchronous, active-high reset
sample_en  in  1  one-clk sampling strobe from clock divider
btn_in  in  N_BTN  raw asynchronous button inputs
btn_level  out  N_BTN  debounced level
btn_press  out  N_BTN  1-clk pulse on debounced rise and on each repeat
btn_release  out  N_BTN  1-clk pulse on debounced fall
btn_long  out  N_BTN  high while held >= REPEAT_DELAY samples

Behaviour:
- Interface: one clock (clk). Reset clr is asynchronous and active-high. While clr is high, every flop including the synchronisers is forced to 0, so all outputs read 0.
- Synchroniser: 2-FF per channel, clocked every clk, independent of sample_en.
- Debounce counter (per channel, width clog2(STABLE_SAMPLES+1)):
  - Updates only in cycles where sample_en=1.
  - If the synchronised input != btn_level: cnt++.
  - If it equals btn_level: cnt=0.
  - When an increment would reach STABLE_SAMPLES: btn_level toggles and cnt=0 on that clk edge.
- Latency: input stable -> level change = 2 clk + STABLE_SAMPLES strobes.
- btn_press / btn_release are registered. They are high for exactly the one clk cycle in which btn_level first shows the new value. This holds even if sample_en is tied high.
- Hold FSM (per channel), states IDLE, HELD, REPEAT; hold counter sized for max(REPEAT_DELAY, REPEAT_RATE), saturating:
  - IDLE: on debounced rise -> HELD, hcnt=0.
  - HELD: each strobe with level high does hcnt++. On reaching REPEAT_DELAY:
    - btn_long=1.
    - If REPEAT_MASK[i]=1: btn_press pulse, hcnt=0, go to REPEAT.
    - Otherwise stay in HELD with hcnt saturated.
  - REPEAT: each strobe does hcnt++. On reaching REPEAT_RATE: btn_press pulse, hcnt=0.
  - Any state, debounced fall -> IDLE, hcnt=0. btn_long drops in the same cycle btn_level drops; release pulse in that cycle.
- Simultaneous events:
  - Channels are fully independent and may pulse in the same cycle.
  - A fall wins over a repeat expiry in the same cycle: no press, only release.
- No sample_en: levels, counters and FSM hold. Only the synchronisers advance.
- clr mid-operation: FSM returns to IDLE. A button held through clr is seen as a fresh press STABLE_SAMPLES strobes (+2 clk) after clr deasserts.

Decomposition:
- Shared package (btn_pkg):
  - hold-state enum IDLE/HELD/REPEAT
  - clog2 constant function
  - default timing constants for the 100 MHz board
- Sub-module debounce_chan (one channel: synchroniser, debounce counter, hold FSM, pulse regs). debouncer_multi is a generate loop of N_BTN instances plus the parameter checks.

Test Plan:
Common setup: STABLE_SAMPLES=4, REPEAT_DELAY=8, REPEAT_RATE=3, sample_en every 4th clk, REPEAT_MASK=3'b001.
1. Clean press: btn_in[0] 0->1, hold -> btn_level[0]=1 on 4th strobe after sync; exactly one btn_press[0] pulse of 1 clk; other channels stay 0.
2. Bounce: btn_in[1] pattern per strobe 1,0,1,1,1,1 -> single press, level rises only after 4 consecutive highs (strobe 6); btn_in pulse of 3 strobes -> no level change.
3. Auto-repeat: hold ch0 for 20 strobes past level rise -> btn_long[0] at strobe 8; press pulses at 0, 8, 11, 14, 17, 20 (6 total). Same hold on ch2 (mask 0) -> 1 press, btn_long[2] still at 8.
4. Release: release ch0 in REPEAT -> btn_release[0] 1 clk after 4 strobes; btn_level and btn_long drop same cycle; no press at a coinciding repeat expiry.
5. Simultaneous: all btn_in rise on same clk -> all three btn_press pulse in the same cycle.
6. Reset mid-REPEAT: assert clr asynchronously (between edges) -> all outputs 0 immediately; button still held -> new press exactly 4 strobes (+2 clk) after clr deasserts.
